// File: rtl/note_sequencer.sv
// Steps through a programmable pattern of notes at a programmable tempo and
// emits the divider half-period plus a voice gate for each step.
module note_sequencer #(
  parameter int NUM_STEPS = 16,
  parameter int BASE_HALF = 7103,
  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [IDX_W-1:0] seq_last,
  input  logic [31:0]      tempo_div,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [5:0]       wr_data,
  output logic [31:0]      half_period,
  output logic             gate,
  output logic [IDX_W-1:0] step_idx,
  output logic             step_strobe,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE, S_PLAY} state_e;

  // Equal-tempered table, one semitone per code, rounded half-up at elaboration.
  function automatic logic [31:0] note_half(input int code);
    real r;
    if (code < 1 || code > 25) return 32'd0;
    r = real'(BASE_HALF) * (2.0 ** (real'(1 - code) / 12.0));
    return 32'($rtoi($floor(r + 0.5)) - 1);
  endfunction

  logic [31:0] note_rom [32];
  for (genvar g = 0; g < 32; g++) begin : g_rom
    localparam logic [31:0] HALF = note_half(g);
    assign note_rom[g] = HALF;
  end

  state_e           state_q, state_d;
  logic [5:0]       pat_q [NUM_STEPS];
  logic [5:0]       pat_d [NUM_STEPS];
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d, fetch_idx, last_clamp;
  logic [31:0]      tick_q, tick_d, tempo_q, tempo_d, hp_q, hp_d, g_len;
  logic             tie_q, tie_d, gate_q, gate_d, strobe_q, strobe_d;
  logic             done_q, done_d, busy_q, busy_d, fetch;
  logic [5:0]       fetch_word;

  always_comb begin
    pat_d = pat_q;
    if (wr_en && (int'(wr_addr) < NUM_STEPS)) pat_d[wr_addr] = wr_data;
  end

  assign last_clamp = (int'(seq_last) >= NUM_STEPS) ? IDX_W'(NUM_STEPS - 1) : seq_last;
  // Gate gap is a quarter step; for T < 4 the shift is zero so the gate fills the step.
  assign g_len      = tempo_q - (tempo_q >> 2);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    tick_d     = tick_q;
    tempo_d    = tempo_q;
    hp_d       = hp_q;
    tie_d      = tie_q;
    gate_d     = gate_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    fetch      = 1'b0;
    fetch_idx  = '0;
    fetch_word = '0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_PLAY;
          tempo_d = (tempo_div == 32'd0) ? 32'd1 : tempo_div;
          last_d  = last_clamp;
          idx_d   = '0;
          tick_d  = '0;
          fetch   = 1'b1;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
          tick_d  = '0;
          hp_d    = '0;
          tie_d   = 1'b0;
          gate_d  = 1'b0;
        end else if (tick_q == tempo_q - 32'd1) begin
          tick_d = '0;
          if (idx_q != last_q) begin
            idx_d     = idx_q + IDX_W'(1);
            fetch_idx = idx_q + IDX_W'(1);
            fetch     = 1'b1;
          end else if (loop_en) begin
            idx_d = '0;
            fetch = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            hp_d    = '0;
            tie_d   = 1'b0;
            gate_d  = 1'b0;
          end
        end else begin
          tick_d = tick_q + 32'd1;
          gate_d = (hp_q != 32'd0) && (tie_q || ((tick_q + 32'd1) < g_len));
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Step data is sampled from the registered store, so a same-cycle write is not seen.
    if (fetch) begin
      fetch_word = pat_q[fetch_idx];
      hp_d       = note_rom[fetch_word[4:0]];
      tie_d      = fetch_word[5];
      gate_d     = (note_rom[fetch_word[4:0]] != 32'd0);
      strobe_d   = 1'b1;
    end

    busy_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      tick_q   <= '0;
      tempo_q  <= '0;
      hp_q     <= '0;
      tie_q    <= 1'b0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) pat_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      tick_q   <= tick_d;
      tempo_q  <= tempo_d;
      hp_q     <= hp_d;
      tie_q    <= tie_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      for (int i = 0; i < NUM_STEPS; i++) pat_q[i] <= pat_d[i];
    end
  end

  assign half_period = hp_q;
  assign gate        = gate_q;
  assign step_idx    = idx_q;
  assign step_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus queues per-cycle expectations,
// a negedge monitor checks every cycle in which the sequencer drives anything.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stop, loop_en, wr_en;
  logic [3:0]  seq_last, wr_addr, step_idx;
  logic [31:0] tempo_div, half_period;
  logic [5:0]  wr_data;
  logic        gate, step_strobe, busy, done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic        strobe;
    logic [3:0]  idx;
    logic        idx_any;
    logic [31:0] hp;
    logic        gate;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  note_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .seq_last(seq_last), .tempo_div(tempo_div), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .half_period(half_period), .gate(gate), .step_idx(step_idx),
    .step_strobe(step_strobe), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (busy || done || step_strobe || gate || (half_period != 32'd0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output t=%0t got strobe=%0b idx=%0d hp=%0d gate=%0b done=%0b busy=%0b, required idle",
                 $time, step_strobe, step_idx, half_period, gate, done, busy);
      end else begin
        mon_e = exp_q.pop_front();
        if (step_strobe !== mon_e.strobe || half_period !== mon_e.hp || gate !== mon_e.gate ||
            done !== mon_e.done || busy !== mon_e.busy || (!mon_e.idx_any && step_idx !== mon_e.idx)) begin
          errors++;
          $display("FAIL step_cycle t=%0t got strobe=%0b idx=%0d hp=%0d gate=%0b done=%0b busy=%0b, required strobe=%0b idx=%0d hp=%0d gate=%0b done=%0b busy=%0b",
                   $time, step_strobe, step_idx, half_period, gate, done, busy,
                   mon_e.strobe, mon_e.idx, mon_e.hp, mon_e.gate, mon_e.done, mon_e.busy);
        end
      end
    end
  end

  task automatic push_step(input int idx, input int hp, input int g, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.strobe  = (k == 0);
      e.idx     = 4'(idx);
      e.idx_any = 1'b0;
      e.hp      = 32'(hp);
      e.gate    = (k < g);
      e.done    = 1'b0;
      e.busy    = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_done();
    exp_t e;
    e = '0;
    e.idx_any = 1'b1;
    e.done    = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic write_step(input int addr, input int data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_data = 6'(data);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns at the negedge of the first strobe cycle.
  task automatic start_play(input int last, input int tempo);
    @(negedge clk);
    seq_last = 4'(last); tempo_div = 32'(tempo); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy || done || step_strobe || gate || half_period != 32'd0 || step_idx != 4'd0) begin
      errors++;
      $display("FAIL %s got busy=%0b done=%0b strobe=%0b gate=%0b hp=%0d idx=%0d, required all 0",
               name, busy, done, step_strobe, gate, half_period, step_idx);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (busy || done || step_strobe || gate || half_period != 32'd0) begin
      errors++;
      $display("FAIL %s got busy=%0b done=%0b strobe=%0b gate=%0b hp=%0d, required all 0",
               name, busy, done, step_strobe, gate, half_period);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d expected cycles unseen, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; wr_en = 1'b0;
    seq_last = '0; wr_addr = '0; tempo_div = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b0;

    // Three tones, non-looping
    write_step(0, 1);
    write_step(1, 13);
    write_step(2, 25);
    push_step(0, 7102, 6, 8);
    push_step(1, 3551, 6, 8);
    push_step(2, 1775, 6, 8);
    push_done();
    start_play(2, 8);
    drain("basic");

    // Looping, then loop_en cleared during the second pass
    loop_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      push_step(0, 7102, 6, 8);
      push_step(1, 3551, 6, 8);
      push_step(2, 1775, 6, 8);
    end
    push_done();
    start_play(2, 8);
    repeat (30) @(negedge clk);
    loop_en = 1'b0;
    drain("loop");

    // Rest step and tied step
    write_step(1, 0);
    write_step(2, 45);
    push_step(0, 7102, 6, 8);
    push_step(1, 0, 0, 8);
    push_step(2, 3551, 8, 8);
    push_done();
    start_play(2, 8);
    drain("rest_tie");

    // tempo_div = 0 plays one cycle per step
    write_step(1, 13);
    write_step(3, 25);
    push_step(0, 7102, 1, 1);
    push_step(1, 3551, 1, 1);
    push_step(2, 3551, 1, 1);
    push_step(3, 1775, 1, 1);
    push_done();
    start_play(3, 0);
    drain("tempo0");

    // stop in the third cycle of step 1
    push_step(0, 7102, 6, 8);
    push_step(1, 3551, 6, 3);
    start_play(2, 8);
    repeat (10) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_quiet("after_stop");
    drain("stop");

    // start and stop together from IDLE
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_quiet("start_stop_1");
    @(negedge clk);
    check_quiet("start_stop_2");

    // Write to the playing step lands on the revisit; then reset mid-play
    write_step(2, 25);
    loop_en = 1'b1;
    push_step(0, 7102, 6, 8);
    push_step(1, 3551, 6, 8);
    push_step(2, 1775, 6, 8);
    push_step(0, 1775, 6, 4);
    start_play(2, 8);
    repeat (3) @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 6'd25;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (23) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid_play_reset");
    reset = 1'b0;
    loop_en = 1'b0;
    drain("write_revisit");

    // Pattern was cleared by reset: all rests
    push_step(0, 0, 0, 8);
    push_step(1, 0, 0, 8);
    push_step(2, 0, 0, 8);
    push_done();
    start_play(2, 8);
    drain("cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream control stage for the tone path. It steps through a small programmable pattern of notes at a programmable tempo.
- For each step it outputs the divider half-period value that the clock-divider/sine-generator voice consumes, plus a gate that enables the voice.
- One instance drives one voice. The top level instantiates one per voice and loads patterns through the write port.

Parameters:
- NUM_STEPS, 16, pattern depth in steps; step index width is clog2(NUM_STEPS), 4 at default.
- BASE_HALF, 7103, half-period count+1 of note 1; defines the note table.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begin playback at step 0
- stop  in  1  single-cycle pulse; abort playback
- loop_en  in  1  1 = wrap to step 0 after last step; sampled at end of last step
- seq_last  in  4  index of last step to play; latched at start
- tempo_div  in  32  clk cycles per step; latched at start; 0 treated as 1
- wr_en  in  1  pattern write strobe
- wr_addr  in  4  pattern step address
- wr_data  in  6  [5]=tie, [4:0]=note (0 = rest, 1..25 = notes, 26..31 = rest)
- half_period  out  32  divider stop value for current note; 0 when rest or idle
- gate  out  1  voice enable
- step_idx  out  4  current step index
- step_strobe  out  1  one-cycle pulse at each step start
- busy  out  1  high while playing
- done  out  1  one-cycle pulse when a non-looping pattern finishes

Behaviour:
- Reset: all outputs 0. Pattern store (NUM_STEPS x 6 register array) cleared to 0 (all rests). FSM goes to IDLE. Latched tempo and seq_last are 0.
- Note table: constant ROM. Entry n (1..25) = round(BASE_HALF / 2^((n-1)/12)) - 1, with round-half-up.
  - Entry 1 = 7102 (0x1BBE).
  - Entry 13 = 3551.
  - Entry 25 = 1775.
  - Note codes 0 and 26..31 give half_period 0 and gate 0 for the whole step.
- FSM states: IDLE, PLAY.
  - IDLE -> PLAY on start (and not stop).
    - On that edge: latch T = max(tempo_div, 1) and seq_last; set step_idx = 0.
    - In the next cycle: step_strobe = 1, busy = 1, half_period/gate reflect step 0.
  - In PLAY, tick counter runs 0..T-1; outputs for the step are stable throughout it.
  - At tick T-1:
    - if step_idx != seq_last: step_idx+1, and the following cycle has a strobe.
    - if step_idx == seq_last and loop_en = 1: step_idx = 0 with a strobe.
    - if step_idx == seq_last and loop_en = 0: go to IDLE; the following cycle has done = 1, busy = 0, gate = 0, half_period = 0.
  - Step period is exactly T cycles, measured strobe to strobe.
- Gate:
  - Gate is high from the strobe cycle for G = T - (T>>2) cycles, then low for the rest of the step.
  - If the tie bit is set, gate stays high for the whole step.
  - T < 4 gives G = T (no gap).
  - half_period is held for the full step, including the gap.
- stop in PLAY: the following cycle is IDLE, gate = 0, half_period = 0, busy = 0, no done pulse. stop in IDLE: no effect.
- start while in PLAY: ignored; tempo and seq_last are not re-latched.
- start and stop in the same cycle: stop wins.
- seq_last >= NUM_STEPS: clamped to NUM_STEPS-1 when latched.
- Pattern writes:
  - Allowed at any time; take effect on the next clk edge.
  - Step data is fetched once, at step start, and held for the step.
  - A write to the step being fetched in the same cycle returns the old data.
  - A write to the currently playing step takes effect on its next visit.
- reset asserted mid-play: reset behaviour applies on that edge, including clearing the pattern.

Test Plan:
- Reset, write steps 0..2 = notes 1, 13, 25 (tie = 0); seq_last = 2, tempo_div = 8, loop_en = 0; pulse start.
  - Strobes 8 cycles apart.
  - half_period = 7102, 3551, 1775.
  - gate high 6 cycles, low 2 cycles each step.
  - done pulses once, 24 cycles after the first strobe; busy falls with it.
- Same pattern with loop_en = 1: after step 2, step_idx returns to 0 with a strobe 8 cycles later. Clear loop_en mid-run: playback ends after the next step 2 with a done pulse.
- Step 1 = note 0, step 2 = tie + note 13, tempo_div = 8.
  - Step 1: half_period = 0, gate = 0 all 8 cycles.
  - Step 2: gate high all 8 cycles.
- tempo_div = 0 with seq_last = 3: strobe every cycle, gate continuously high, done 4 cycles after the first strobe.
- Pulse stop in the 3rd cycle of step 1: the next cycle has busy = 0, gate = 0, half_period = 0, and there is no done pulse. start and stop in the same cycle from IDLE: stays IDLE.
- While step 0 plays, write step 0 = note 25: the current step keeps its old value; the value becomes 1775 on the loop revisit. Assert reset mid-play: all outputs 0 the next cycle, and a subsequent start plays rests.
